camera_capture: RTL and testbench

CAMERA_CAPTURE -- requirements
Module: camera_capture

---
 rtl/camera_capture_pkg.sv | 32 +++
 rtl/camera_capture_if.sv | 12 +
 rtl/camera_capture_ram.sv | 21 ++
 rtl/camera_capture.sv | 124 ++++++++++++
 tb/tb_camera_capture.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_capture_pkg.sv
// Shared constants, FSM encoding, debug struct and gray-conversion helper
// for the camera capture block.
package camera_pkg;

    localparam int FRAME_BYTES   = 75;
    localparam int BYTES_PER_PIX = 3;
    localparam int NUM_PIX       = 25;
    localparam int GRAY_SHIFT    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [4:0] idx;
        logic [6:0] req_cnt;
        logic [6:0] byte_cnt;
    } dbg_t;

    // R + 2G + B is at most 1020, so a 10-bit sum never overflows.
    function automatic logic [7:0] gray_of(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return 8'(sum >> GRAY_SHIFT);
    endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Pixel output stream. A pixel transfers on a rising clk edge where
// pix_valid and pix_ready are both high; while pix_valid=1 and
// pix_ready=0 the master holds pix_data and pix_last stable.
interface camera_capture_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_last;

    modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
    modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/camera_capture_ram.sv
// 25x8 gray pixel store: one synchronous write port, one combinational read port.
module gray_frame_ram
    import camera_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [NUM_PIX];

    always_ff @(posedge clk) begin
        if (we && (waddr < 5'(NUM_PIX))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr < 5'(NUM_PIX)) ? mem[raddr] : 8'h00;
endmodule

// File: rtl/camera_capture.sv
// Captures one 5x5 RGB frame from the camera, converts each pixel to gray
// and streams the 25 gray pixels out through a valid/ready interface.
module camera_capture
    import camera_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    camera_en,
    input  logic                    cam_valid,
    input  logic [7:0]              cam_data,
    output logic                    busy,
    output logic                    frame_done,
    camera_capture_if.master        pix,
    output dbg_t                    dbg
);
    localparam logic [6:0] REQ_LAST  = 7'(FRAME_BYTES - 1);
    localparam logic [6:0] BYTE_LAST = 7'(FRAME_BYTES - 1);
    localparam logic [4:0] IDX_LAST  = 5'(NUM_PIX - 1);

    state_t     state;
    logic [6:0] req_cnt;
    logic [6:0] byte_cnt;
    logic [1:0] phase;
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [4:0] idx;
    logic       pix_valid_q;
    logic       pix_last_q;

    logic       accept;
    logic       ram_we;
    logic [4:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    assign accept    = (state == CAPTURE) && cam_valid;
    assign ram_we    = accept && (phase == 2'd2);
    assign ram_waddr = 5'(byte_cnt / 7'(BYTES_PER_PIX));
    assign ram_wdata = gray_of(r_q, g_q, cam_data);

    gray_frame_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_cnt     <= '0;
            byte_cnt    <= '0;
            phase       <= '0;
            idx         <= '0;
            camera_en   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CAPTURE;
                        camera_en <= 1'b1;
                        req_cnt   <= '0;
                        byte_cnt  <= '0;
                        phase     <= '0;
                        idx       <= '0;
                    end
                end
                CAPTURE: begin
                    // Requests run for a fixed 75 cycles; bytes may lag behind them.
                    if (camera_en) begin
                        if (req_cnt == REQ_LAST) camera_en <= 1'b0;
                        else                     req_cnt   <= req_cnt + 7'd1;
                    end
                    if (accept) begin
                        case (phase)
                            2'd0:    r_q <= cam_data;
                            2'd1:    g_q <= cam_data;
                            default: ;
                        endcase
                        phase    <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                        byte_cnt <= byte_cnt + 7'd1;
                        if (byte_cnt == BYTE_LAST) begin
                            state       <= SEND;
                            pix_valid_q <= 1'b1;
                            pix_last_q  <= 1'b0;
                            idx         <= '0;
                        end
                    end
                end
                SEND: begin
                    if (pix.pix_ready) begin
                        if (idx == IDX_LAST) begin
                            state       <= IDLE;
                            pix_valid_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            frame_done  <= 1'b1;
                        end else begin
                            idx        <= idx + 5'd1;
                            pix_last_q <= (idx == IDX_LAST - 5'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign pix.pix_valid = pix_valid_q;
    assign pix.pix_last  = pix_last_q;
    assign pix.pix_data  = pix_valid_q ? ram_rdata : 8'h00;

    assign dbg.state    = state;
    assign dbg.idx      = idx;
    assign dbg.req_cnt  = req_cnt;
    assign dbg.byte_cnt = byte_cnt;
endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: camera source model, frame runner and
// one task per scenario with hand-computed expected pixels and cycle numbers.
module tb_camera_capture;
    import camera_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       camera_en;
    logic       cam_valid;
    logic [7:0] cam_data;
    logic       busy;
    logic       frame_done;
    dbg_t       dbg;

    camera_capture_if pix ();

    camera_capture dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .camera_en  (camera_en),
        .cam_valid  (cam_valid),
        .cam_data   (cam_data),
        .busy       (busy),
        .frame_done (frame_done),
        .pix        (pix),
        .dbg        (dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Camera model: each enabled cycle queues one byte, delivered from the next cycle on.
    logic [7:0] frame_bytes [FRAME_BYTES];
    logic       model_clr;
    int         gap_len = 0;
    int         gap_at  = 10;
    int         m_req, m_sent, m_gap_used;

    always @(posedge clk) begin
        if (model_clr) begin
            m_req <= 0; m_sent <= 0; m_gap_used <= 0;
            cam_valid <= 1'b0; cam_data <= 'z;
        end else begin
            if (camera_en) m_req <= m_req + 1;
            if (m_sent == gap_at && m_gap_used < gap_len) begin
                m_gap_used <= m_gap_used + 1;
                cam_valid <= 1'b0; cam_data <= 'z;
            end else if (m_sent < m_req + (camera_en ? 1 : 0) && m_sent < FRAME_BYTES) begin
                cam_valid <= 1'b1; cam_data <= frame_bytes[m_sent];
                m_sent <= m_sent + 1;
            end else begin
                cam_valid <= 1'b0; cam_data <= 'z;
            end
        end
    end

    function automatic logic [7:0] ref_gray(input int p);
        int s;
        s = int'(frame_bytes[3*p]) + 2 * int'(frame_bytes[3*p+1]) + int'(frame_bytes[3*p+2]);
        return 8'(s / 4);
    endfunction

    // Results of the last run_frame call.
    logic [7:0] got_pix [32];
    logic [4:0] got_idx [32];
    logic       got_last [32];
    logic [7:0] st_data [4];
    logic [4:0] st_idx [4];
    int n_pix, en_cnt, en_first, en_last, valid_first, hs_first, hs_last;
    int done_cyc, done_cnt, busy_cnt, last_cnt, stall_used;

    task automatic run_frame(input int stall_idx, input int stall_len,
                             input int restart_cyc, input int gap);
        int cyc;
        n_pix = 0; en_cnt = 0; en_first = -1; en_last = -1; valid_first = -1;
        hs_first = -1; hs_last = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
        last_cnt = 0; stall_used = 0; gap_len = gap;
        @(negedge clk); model_clr = 1'b1; pix.pix_ready = 1'b1;
        @(negedge clk); model_clr = 1'b0; start = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (cyc < 300 && !(done_cyc >= 0 && cyc > done_cyc + 5)) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            if (pix.pix_valid && dbg.idx == 5'(stall_idx) && stall_used < stall_len) begin
                pix.pix_ready = 1'b0;
                if (stall_used < 4) begin
                    st_data[stall_used] = pix.pix_data;
                    st_idx[stall_used]  = dbg.idx;
                end
                stall_used++;
            end else begin
                pix.pix_ready = 1'b1;
            end
            if (camera_en) begin
                en_cnt++;
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
            end
            if (busy) busy_cnt++;
            if (pix.pix_valid && valid_first < 0) valid_first = cyc;
            if (pix.pix_valid && pix.pix_ready) begin
                if (n_pix < 32) begin
                    got_pix[n_pix] = pix.pix_data;
                    got_idx[n_pix] = dbg.idx;
                    got_last[n_pix] = pix.pix_last;
                end
                if (pix.pix_last) last_cnt++;
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                n_pix++;
            end
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix.pix_ready = 1'b0; model_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (camera_en !== 1'b0) begin n_bad++; $display("FAIL reset_camera_en got %b want 0", camera_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (pix.pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pix_valid got %b want 0", pix.pix_valid); end
        n_cmp++; if (pix.pix_last !== 1'b0) begin n_bad++; $display("FAIL reset_pix_last got %b want 0", pix.pix_last); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if (pix.pix_data !== 8'h00) begin n_bad++; $display("FAIL reset_pix_data got %h want 00", pix.pix_data); end
        n_cmp++; if (dbg.state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dbg.state); end
        n_cmp++; if (dbg.idx !== 5'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", dbg.idx); end
        rst = 1'b0; model_clr = 1'b0;
    endtask

    task automatic test_full_frame();
        run_frame(-1, 0, -1, 0);
        n_cmp++; if (en_cnt != 75 || en_first != 1 || en_last != 75) begin n_bad++; $display("FAIL full_camera_en got %0d cycles %0d..%0d want 75 cycles 1..75", en_cnt, en_first, en_last); end
        n_cmp++; if (valid_first != 77) begin n_bad++; $display("FAIL full_first_valid got cycle %0d want 77", valid_first); end
        n_cmp++; if (hs_first != 77 || hs_last != 101) begin n_bad++; $display("FAIL full_pixel_cycles got %0d..%0d want 77..101", hs_first, hs_last); end
        n_cmp++; if (done_cyc != 102 || done_cnt != 1) begin n_bad++; $display("FAIL full_frame_done got cycle %0d count %0d want cycle 102 count 1", done_cyc, done_cnt); end
        n_cmp++; if (busy_cnt != 101) begin n_bad++; $display("FAIL full_busy_cycles got %0d want 101", busy_cnt); end
        n_cmp++; if (n_pix != 25) begin n_bad++; $display("FAIL full_pixel_count got %0d want 25", n_pix); end
        n_cmp++; if (got_pix[0] !== 8'h62) begin n_bad++; $display("FAIL full_pixel0 got %h want 62", got_pix[0]); end
        n_cmp++; if (got_pix[1] !== 8'hAE) begin n_bad++; $display("FAIL full_pixel1 got %h want ae", got_pix[1]); end
        n_cmp++; if (got_pix[24] !== 8'hEF || got_last[24] !== 1'b1) begin n_bad++; $display("FAIL full_pixel24 got %h last %b want ef last 1", got_pix[24], got_last[24]); end
        n_cmp++; if (last_cnt != 1) begin n_bad++; $display("FAIL full_last_count got %0d want 1", last_cnt); end
        for (int i = 0; i < NUM_PIX; i++) begin
            n_cmp++; if (got_pix[i] !== ref_gray(i)) begin n_bad++; $display("FAIL full_pixel[%0d] got %h want %h", i, got_pix[i], ref_gray(i)); end
        end
    endtask

    task automatic test_arith_corners();
        run_frame(-1, 0, -1, 0);
        n_cmp++; if (got_pix[2] !== 8'hFF) begin n_bad++; $display("FAIL arith_all_ff got %h want ff", got_pix[2]); end
        n_cmp++; if (got_pix[3] !== 8'h00) begin n_bad++; $display("FAIL arith_all_00 got %h want 00", got_pix[3]); end
        n_cmp++; if (got_pix[4] !== 8'h00) begin n_bad++; $display("FAIL arith_r03 got %h want 00", got_pix[4]); end
    endtask

    task automatic test_backpressure();
        run_frame(5, 3, -1, 0);
        n_cmp++; if (stall_used != 3) begin n_bad++; $display("FAIL bp_stall_cycles got %0d want 3", stall_used); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (st_data[k] !== ref_gray(5) || st_idx[k] !== 5'd5) begin n_bad++; $display("FAIL bp_hold[%0d] got data %h idx %0d want %h idx 5", k, st_data[k], st_idx[k], ref_gray(5)); end
        end
        n_cmp++; if (n_pix != 25) begin n_bad++; $display("FAIL bp_pixel_count got %0d want 25", n_pix); end
        for (int i = 0; i < NUM_PIX; i++) begin
            n_cmp++; if (got_pix[i] !== ref_gray(i) || got_idx[i] !== 5'(i)) begin n_bad++; $display("FAIL bp_pixel[%0d] got %h idx %0d want %h", i, got_pix[i], got_idx[i], ref_gray(i)); end
        end
        n_cmp++; if (done_cyc != 105 || done_cnt != 1) begin n_bad++; $display("FAIL bp_frame_done got cycle %0d count %0d want cycle 105 count 1", done_cyc, done_cnt); end
    endtask

    task automatic test_start_ignored();
        run_frame(-1, 0, 40, 0);
        n_cmp++; if (en_cnt != 75) begin n_bad++; $display("FAIL restart_camera_en got %0d want 75", en_cnt); end
        n_cmp++; if (done_cnt != 1 || done_cyc != 102) begin n_bad++; $display("FAIL restart_frame_done got count %0d cycle %0d want 1 at 102", done_cnt, done_cyc); end
        n_cmp++; if (dbg.state !== IDLE || busy !== 1'b0) begin n_bad++; $display("FAIL restart_not_queued got state %0d busy %b want IDLE busy 0", dbg.state, busy); end
    endtask

    task automatic test_reset_mid_capture();
        @(negedge clk); model_clr = 1'b1; pix.pix_ready = 1'b1;
        @(negedge clk); model_clr = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_cmp++; if (camera_en !== 1'b1) begin n_bad++; $display("FAIL rst_mid_en_before got %b want 1", camera_en); end
        rst = 1'b1; model_clr = 1'b1;
        @(negedge clk);
        n_cmp++; if (camera_en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_cycle31 got en %b busy %b want 0 0", camera_en, busy); end
        n_cmp++; if (dbg.req_cnt !== 7'd0 || dbg.byte_cnt !== 7'd0) begin n_bad++; $display("FAIL rst_mid_counters got req %0d byte %0d want 0 0", dbg.req_cnt, dbg.byte_cnt); end
        rst = 1'b0; model_clr = 1'b0;
        run_frame(-1, 0, -1, 0);
        n_cmp++; if (got_pix[0] !== 8'h62) begin n_bad++; $display("FAIL rst_mid_pixel0 got %h want 62", got_pix[0]); end
        n_cmp++; if (n_pix != 25 || done_cyc != 102) begin n_bad++; $display("FAIL rst_mid_frame got %0d pixels done %0d want 25 done 102", n_pix, done_cyc); end
        for (int i = 0; i < NUM_PIX; i++) begin
            n_cmp++; if (got_pix[i] !== ref_gray(i)) begin n_bad++; $display("FAIL rst_mid_pixel[%0d] got %h want %h", i, got_pix[i], ref_gray(i)); end
        end
    endtask

    task automatic test_cam_gap();
        run_frame(-1, 0, -1, 4);
        gap_len = 0;
        n_cmp++; if (en_cnt != 75) begin n_bad++; $display("FAIL gap_camera_en got %0d want 75", en_cnt); end
        n_cmp++; if (valid_first != 81 || done_cyc != 106) begin n_bad++; $display("FAIL gap_timing got valid %0d done %0d want 81 106", valid_first, done_cyc); end
        n_cmp++; if (n_pix != 25) begin n_bad++; $display("FAIL gap_pixel_count got %0d want 25", n_pix); end
        for (int i = 0; i < NUM_PIX; i++) begin
            n_cmp++; if (got_pix[i] !== ref_gray(i)) begin n_bad++; $display("FAIL gap_pixel[%0d] got %h want %h", i, got_pix[i], ref_gray(i)); end
        end
    endtask

    initial begin
        for (int p = 0; p < NUM_PIX; p++) begin
            frame_bytes[3*p]   = 8'(p * 37 + 5);
            frame_bytes[3*p+1] = 8'(p * 91 + 13);
            frame_bytes[3*p+2] = 8'(p * 53 + 200);
        end
        {frame_bytes[0],  frame_bytes[1],  frame_bytes[2]}  = {8'hBC, 8'h27, 8'h81};
        {frame_bytes[3],  frame_bytes[4],  frame_bytes[5]}  = {8'hFF, 8'hCE, 8'h1F};
        {frame_bytes[6],  frame_bytes[7],  frame_bytes[8]}  = {8'hFF, 8'hFF, 8'hFF};
        {frame_bytes[9],  frame_bytes[10], frame_bytes[11]} = {8'h00, 8'h00, 8'h00};
        {frame_bytes[12], frame_bytes[13], frame_bytes[14]} = {8'h03, 8'h00, 8'h00};
        {frame_bytes[72], frame_bytes[73], frame_bytes[74]} = {8'hE1, 8'hFF, 8'hDE};

        test_reset();
        test_full_frame();
        test_arith_corners();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_capture();
        test_cam_gap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
